// File: rtl/decompress_stream.sv
// Two-stage streaming Kyber coefficient decompressor: y -> round(Q*y / 2^D), ties up.
// Each output carries its position within the polynomial and flags the last one.
module decompress_stream #(
  parameter int unsigned D = 10,
  parameter int unsigned Q = 3329,
  parameter int unsigned N = 256
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [D-1:0] in_coeff,
  output logic         in_ready,
  output logic         out_valid,
  output logic [11:0]  out_coeff,
  output logic [7:0]   out_index,
  output logic         out_last,
  input  logic         out_ready,
  output logic         frame_done
);

  // y*Q + 2^(D-1) stays below 4096 * 2^D, so D+12 bits never overflow.
  localparam int unsigned PW      = D + 12;
  localparam logic [PW-1:0] Half  = PW'(1) << (D - 1);
  localparam logic [7:0]  LastIdx = 8'(N - 1);

  logic          r_s1_valid;
  logic [PW-1:0] r_s1_prod;
  logic [7:0]    r_s1_idx;
  logic          r_s2_valid;
  logic [11:0]   r_s2_coeff;
  logic [7:0]    r_s2_idx;
  logic          r_s2_last;
  logic [7:0]    r_in_cnt;
  logic          r_frame_done;

  logic          w_adv;
  logic          w_in_xfer;
  logic          w_out_xfer;
  logic [PW-1:0] w_prod;
  logic [PW-1:0] w_sum;
  logic [11:0]   w_round;

  assign w_adv      = !r_s2_valid || out_ready;
  assign w_in_xfer  = in_valid && w_adv;
  assign w_out_xfer = out_valid && out_ready;
  assign w_prod     = PW'(in_coeff) * PW'(Q);
  assign w_sum      = r_s1_prod + Half;
  assign w_round    = w_sum[D +: 12];

  assign in_ready   = w_adv;
  // Outputs read as zero while reset is applied, before the registers clear.
  assign out_valid  = r_s2_valid && !rst;
  assign out_coeff  = rst ? 12'd0 : r_s2_coeff;
  assign out_index  = rst ? 8'd0 : r_s2_idx;
  assign out_last   = r_s2_valid && r_s2_last && !rst;
  assign frame_done = r_frame_done;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid   <= 1'b0;
      r_s1_prod    <= '0;
      r_s1_idx     <= '0;
      r_s2_valid   <= 1'b0;
      r_s2_coeff   <= '0;
      r_s2_idx     <= '0;
      r_s2_last    <= 1'b0;
      r_in_cnt     <= '0;
      r_frame_done <= 1'b0;
    end else begin
      if (w_adv) begin
        r_s1_valid <= w_in_xfer;
        if (w_in_xfer) begin
          r_s1_prod <= w_prod;
          r_s1_idx  <= r_in_cnt;
        end
        r_s2_valid <= r_s1_valid;
        if (r_s1_valid) begin
          r_s2_coeff <= w_round;
          r_s2_idx   <= r_s1_idx;
          r_s2_last  <= (r_s1_idx == LastIdx);
        end
      end
      if (w_in_xfer) begin
        r_in_cnt <= (r_in_cnt == LastIdx) ? 8'd0 : r_in_cnt + 8'd1;
      end
      r_frame_done <= w_out_xfer && r_s2_last;
    end
  end

endmodule

// File: tb/tb_decompress_stream.sv
// Randomized and directed bench for decompress_stream, scored against a queue-based
// model that computes rounded Q*y/2^D by integer division.
module tb_decompress_stream;

  localparam int Q = 3329;
  localparam int N = 256;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [9:0]  in_coeff;
  logic        in_ready;
  logic        out_valid;
  logic [11:0] out_coeff;
  logic [7:0]  out_index;
  logic        out_last;
  logic        out_ready;
  logic        frame_done;

  logic        d4_valid, d4_in_ready, d4_out_valid, d4_out_last, d4_fd;
  logic [3:0]  d4_coeff;
  logic [11:0] d4_out_coeff;
  logic [7:0]  d4_out_index;
  logic        d1_valid, d1_in_ready, d1_out_valid, d1_out_last, d1_fd;
  logic [0:0]  d1_coeff;
  logic [11:0] d1_out_coeff;
  logic [7:0]  d1_out_index;

  decompress_stream u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_coeff(in_coeff), .in_ready(in_ready),
    .out_valid(out_valid), .out_coeff(out_coeff), .out_index(out_index),
    .out_last(out_last), .out_ready(out_ready), .frame_done(frame_done)
  );

  decompress_stream #(.D(4)) u_d4 (
    .clk(clk), .rst(rst), .in_valid(d4_valid), .in_coeff(d4_coeff), .in_ready(d4_in_ready),
    .out_valid(d4_out_valid), .out_coeff(d4_out_coeff), .out_index(d4_out_index),
    .out_last(d4_out_last), .out_ready(1'b1), .frame_done(d4_fd)
  );

  decompress_stream #(.D(1)) u_d1 (
    .clk(clk), .rst(rst), .in_valid(d1_valid), .in_coeff(d1_coeff), .in_ready(d1_in_ready),
    .out_valid(d1_out_valid), .out_coeff(d1_out_coeff), .out_index(d1_out_index),
    .out_last(d1_out_last), .out_ready(1'b1), .frame_done(d1_fd)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    int coeff;
    int idx;
    int cyc;
    bit lat;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;
  int   model_cnt = 0;
  int   n_in     = 0;
  int   fd_count = 0;
  bit   exp_fd   = 1'b0;
  bit   lat_en   = 1'b0;
  bit   prev_stall = 1'b0;
  int   prev_coeff, prev_idx, prev_last;

  function automatic int ref_round(int y, int d);
    return (2 * y * Q + (1 << d)) / (1 << (d + 1));
  endfunction

  task automatic check(input string tag, input int obs, input int expv);
    n_checks = n_checks + 1;
    assert (obs === expv) n_pass = n_pass + 1;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
  endtask

  // One clock cycle: score outputs at the falling edge, then step past the rising edge.
  task automatic cycle();
    exp_t e;
    bit   ox, ix, popped_last;
    @(negedge clk);
    cyc = cyc + 1;
    check("frame_done", frame_done, exp_fd);
    if (rst) begin
      check("rst_out_valid", out_valid, 0);
      check("rst_out_last", out_last, 0);
      check("rst_out_coeff", out_coeff, 0);
      check("rst_out_index", out_index, 0);
      q.delete();
      model_cnt  = 0;
      exp_fd     = 1'b0;
      prev_stall = 1'b0;
    end else begin
      if (out_ready) check("in_ready_when_out_ready", in_ready, 1);
      if (frame_done) fd_count = fd_count + 1;
      if (prev_stall) begin
        check("stall_out_valid", out_valid, 1);
        check("stall_out_coeff", out_coeff, prev_coeff);
        check("stall_out_index", out_index, prev_idx);
        check("stall_out_last", out_last, prev_last);
      end
      ox = out_valid && out_ready;
      ix = in_valid && in_ready;
      popped_last = 1'b0;
      if (ox) begin
        if (q.size() == 0) begin
          check("spurious_output", 1, 0);
        end else begin
          e = q.pop_front();
          check("out_coeff", out_coeff, e.coeff);
          check("out_index", out_index, e.idx);
          check("out_last", out_last, (e.idx == N - 1) ? 1 : 0);
          if (e.lat) check("latency", cyc - e.cyc, 2);
          popped_last = (e.idx == N - 1);
        end
      end
      if (ix) begin
        e.coeff = ref_round(int'(in_coeff), 10);
        e.idx   = model_cnt;
        e.cyc   = cyc;
        e.lat   = lat_en;
        q.push_back(e);
        model_cnt = (model_cnt + 1) % N;
        n_in = n_in + 1;
      end
      exp_fd     = ox && popped_last;
      prev_stall = out_valid && !out_ready;
      prev_coeff = out_coeff;
      prev_idx   = out_index;
      prev_last  = out_last;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
  endtask

  int ys[4] = '{0, 1, 512, 1023};
  int cnt_limit;

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_coeff = '0; out_ready = 1'b1;
    d4_valid = 1'b0; d4_coeff = '0; d1_valid = 1'b0; d1_coeff = '0;
    repeat (2) @(posedge clk);
    #1;
    cycle();
    cycle();
    rst = 1'b0;

    // Directed vectors at D=10 with latency tracking.
    lat_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_coeff = 10'(ys[i]);
      cycle();
    end
    in_valid = 1'b0;
    repeat (3) cycle();
    check("directed_drained", q.size(), 0);

    // Narrow-width instances.
    d4_valid = 1'b1; d4_coeff = 4'd15; d1_valid = 1'b1; d1_coeff = 1'b1;
    cycle();
    d4_coeff = 4'd8; d1_coeff = 1'b0;
    cycle();
    d4_valid = 1'b0; d1_valid = 1'b0;
    check("d4_valid0", d4_out_valid, 1);
    check("d4_y15", d4_out_coeff, ref_round(15, 4));
    check("d4_idx0", d4_out_index, 0);
    check("d1_y1", d1_out_coeff, ref_round(1, 1));
    cycle();
    check("d4_y8", d4_out_coeff, ref_round(8, 4));
    check("d4_idx1", d4_out_index, 1);
    check("d1_y0", d1_out_coeff, ref_round(0, 1));
    check("d1_idx1", d1_out_index, 1);

    // Full polynomial plus one, no throttling.
    do_reset();
    fd_count = 0;
    for (int i = 0; i < N + 1; i++) begin
      in_valid = 1'b1;
      in_coeff = 10'($urandom_range(0, 1023));
      cycle();
    end
    in_valid = 1'b0;
    repeat (4) cycle();
    check("frame_done_pulses", fd_count, 1);
    check("poly_drained", q.size(), 0);
    lat_en = 1'b0;

    // Backpressure with a full pipeline.
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_coeff = 10'($urandom_range(0, 1023));
      cycle();
    end
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_coeff = 10'($urandom_range(0, 1023));
      #1;
      check("stall_in_ready", in_ready, 0);
      cycle();
    end
    out_ready = 1'b1;
    in_valid  = 1'b0;
    repeat (4) cycle();
    check("stall_drained", q.size(), 0);

    // Random throttling over three polynomials.
    do_reset();
    n_in = 0;
    cnt_limit = 0;
    while ((n_in < 3 * N || q.size() != 0) && cnt_limit < 6000) begin
      in_valid  = (n_in < 3 * N) && ($urandom_range(0, 3) != 0);
      in_coeff  = 10'($urandom_range(0, 1023));
      out_ready = ($urandom_range(0, 2) != 0);
      cycle();
      cnt_limit = cnt_limit + 1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("random_inputs_accepted", n_in, 3 * N);
    check("random_drained", q.size(), 0);
    cycle();

    // Reset in the middle of a polynomial.
    do_reset();
    cnt_limit = 0;
    while (model_cnt != 100 && cnt_limit < 400) begin
      in_valid = 1'b1;
      in_coeff = 10'($urandom_range(0, 1023));
      cycle();
      cnt_limit = cnt_limit + 1;
    end
    check("reached_index_100", model_cnt, 100);
    rst = 1'b1;
    in_coeff = 10'($urandom_range(0, 1023));
    cycle();
    rst = 1'b0;
    in_valid = 1'b0;
    check("post_rst_out_valid", out_valid, 0);
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_coeff = 10'($urandom_range(0, 1023));
      cycle();
    end
    in_valid = 1'b0;
    repeat (4) cycle();
    check("post_rst_drained", q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
